// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache fill types, sizing constants and clog2 helper
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Default geometry; the caches and the arbiter size from these as well.
    localparam int CACHE_WORDS  = 8;
    localparam int CACHE_DATA_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - saturating up-counter with enable, sync clear and terminal-count flag
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_n_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == W'(MAX));
    assign cnt_o = cnt_q;

    // Clear wins over enable; the count holds once it reaches MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (!clr_n_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill engine: issues block word reads, steers returns, writes tag
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = CACHE_DATA_W,
    parameter int WORDS  = CACHE_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic                     mem_grant,
    input  logic                     memory_data_valid,
    input  logic [DATA_W-1:0]        memory_data,
    output logic                     fsm_busy,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic [clog2(WORDS)-1:0]  word_index,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     write_tag_array
);

    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = clog2(WORDS * BPW);
    localparam int IDX_W = clog2(WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    fill_state_e       state_q;
    logic [ADDR_W-1:0] base_q;
    logic              busy_q;

    logic [IDX_W:0]    req_cnt;
    logic              req_done;
    logic [IDX_W-1:0]  ret_cnt;
    logic              ret_last;

    logic              in_fill;
    logic              start_fill;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] req_off;

    assign in_fill    = (state_q == FILL);
    assign start_fill = (state_q == IDLE) && miss_detected;
    assign rd         = in_fill && mem_grant && !req_done;
    assign wr         = in_fill && memory_data_valid;

    // Base has its offset bits cleared, so OR-ing the offset never carries out of the block.
    assign req_off = ADDR_W'(req_cnt) * ADDR_W'(BPW);

    fill_counter #(
        .W   (IDX_W + 1),
        .MAX (WORDS)
    ) u_req_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_n_i (!start_fill),
        .en_i    (rd),
        .cnt_o   (req_cnt),
        .tc_o    (req_done)
    );

    fill_counter #(
        .W   (IDX_W),
        .MAX (WORDS - 1)
    ) u_ret_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_n_i (!start_fill),
        .en_i    (wr),
        .cnt_o   (ret_cnt),
        .tc_o    (ret_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        state_q <= FILL;
                        base_q  <= miss_address & ~OFF_MASK;
                        busy_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (wr && ret_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign fsm_busy         = busy_q;
    assign mem_rd           = rd;
    assign memory_address   = rd ? (base_q | req_off) : '0;
    assign write_data_array = wr;
    assign word_index       = wr ? ret_cnt : '0;
    assign fill_data        = wr ? memory_data : '0;
    assign write_tag_array  = wr && ret_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm against a block-level model
module tb_cache_fill_fsm;

    localparam int WORDS = 8;
    localparam int BPW   = 2;
    localparam int BLK   = WORDS * BPW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, miss_detected, mem_grant, memory_data_valid;
    logic [15:0] miss_address, memory_data;
    logic        fsm_busy, mem_rd, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_data;
    logic [2:0]  word_index;

    logic        r4_rst_n, r4_miss, r4_grant, r4_valid;
    logic [15:0] r4_addr;
    logic [31:0] r4_data;
    logic        o4_busy, o4_rd, o4_wr, o4_tag;
    logic [15:0] o4_addr;
    logic [1:0]  o4_idx;
    logic [31:0] o4_fdata;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_grant         (mem_grant),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_rd            (mem_rd),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_index        (word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    cache_fill_fsm #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) dut4 (
        .clk               (clk),
        .rst_n             (r4_rst_n),
        .miss_detected     (r4_miss),
        .miss_address      (r4_addr),
        .mem_grant         (r4_grant),
        .memory_data_valid (r4_valid),
        .memory_data       (r4_data),
        .fsm_busy          (o4_busy),
        .mem_rd            (o4_rd),
        .memory_address    (o4_addr),
        .write_data_array  (o4_wr),
        .word_index        (o4_idx),
        .fill_data         (o4_fdata),
        .write_tag_array   (o4_tag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Block-level model: one outstanding fill, a count of words asked for and words received.
    bit          m_busy = 1'b0;
    logic [15:0] m_base = '0;
    int          m_req = 0, m_ret = 0;
    int          cyc = 0, lat = 4, last_ready = 0;
    int          pend_t[$];
    int          n_rd_obs = 0, n_tag_obs = 0, last_rd_cyc = 0, last_tag_cyc = 0;
    logic [15:0] last_rd_addr = '0;

    task automatic step(input bit rst, input bit miss, input logic [15:0] addr,
                        input bit grant, input bit junk);
        bit exp_rd, exp_wr, exp_tag;
        int ready;
        #1;
        rst_n         = !rst;
        miss_detected = miss;
        miss_address  = addr;
        mem_grant     = grant;
        memory_data   = 16'($urandom);
        if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
            memory_data_valid = 1'b1;
            void'(pend_t.pop_front());
        end else begin
            memory_data_valid = junk && !m_busy && ($urandom_range(0, 1) == 1);
        end
        #4;
        exp_rd  = m_busy && grant && (m_req < WORDS);
        exp_wr  = m_busy && memory_data_valid;
        exp_tag = exp_wr && (m_ret == WORDS - 1);
        chk("fsm_busy", fsm_busy, m_busy);
        chk("mem_rd", mem_rd, exp_rd);
        chk("write_data_array", write_data_array, exp_wr);
        chk("write_tag_array", write_tag_array, exp_tag);
        if (exp_rd && mem_rd) chk("memory_address", memory_address, m_base + 16'(m_req * BPW));
        if (exp_wr && write_data_array) begin
            chk("word_index", word_index, m_ret);
            chk("fill_data", fill_data, memory_data);
        end
        if (mem_rd) begin
            n_rd_obs++;
            last_rd_addr = memory_address;
            last_rd_cyc  = cyc;
        end
        if (write_tag_array) begin
            n_tag_obs++;
            last_tag_cyc = cyc;
        end
        if (rst) begin
            m_busy = 1'b0; m_req = 0; m_ret = 0; m_base = '0;
            pend_t.delete();
            last_ready = 0;
        end else if (!m_busy) begin
            if (miss) begin
                m_busy = 1'b1;
                m_base = 16'(int'(addr) / BLK * BLK);
                m_req  = 0;
                m_ret  = 0;
            end
        end else begin
            if (exp_rd) begin
                ready = cyc + lat;
                if (ready <= last_ready) ready = last_ready + 1;
                pend_t.push_back(ready);
                last_ready = ready;
                m_req++;
            end
            if (exp_wr) m_ret++;
            if (exp_tag) m_busy = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    int          t0;
    int          p4[$];
    logic [15:0] a4[$];
    int          n4_wr = 0, n4_tag = 0, tag4_at = 0;

    initial begin
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0; mem_grant = 1'b0;
        memory_data_valid = 1'b0; memory_data = '0;
        r4_rst_n = 1'b0; r4_miss = 1'b0; r4_addr = '0; r4_grant = 1'b0;
        r4_valid = 1'b0; r4_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", fsm_busy, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_addr", memory_address, 0);
        chk("reset_wr", write_data_array, 0);
        chk("reset_idx", word_index, 0);
        chk("reset_fill_data", fill_data, 0);
        chk("reset_tag", write_tag_array, 0);
        @(posedge clk);

        // Basic fill with a stray miss in the middle.
        lat = 4; n_rd_obs = 0; t0 = cyc;
        step(0, 1, 16'h1236, 1, 0);
        for (int i = 1; i <= 14; i++) step(0, i == 3, 16'hABCD, 1, 0);
        chk("basic_tag_cycle", last_tag_cyc - t0, 12);
        chk("basic_rd_count", n_rd_obs, 8);

        // Grant stall on cycles 3..5.
        n_rd_obs = 0; t0 = cyc;
        step(0, 1, 16'h1236, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 16'h0000, !(i >= 3 && i <= 5), 0);
            if (i == 6) begin
                chk("stall_resume_cycle", last_rd_cyc - t0, 6);
                chk("stall_resume_addr", last_rd_addr, 16'h1234);
            end
        end
        chk("stall_rd_count", n_rd_obs, 8);

        for (int i = 0; i < 10; i++) step(0, 0, 16'h0000, 1, 1);

        // Reset in the middle of a fill.
        n_tag_obs = 0;
        step(0, 1, 16'h2468, 1, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, 16'h0000, 1, 0);
        step(1, 0, 16'h0000, 1, 0);
        #1;
        chk("abort_busy", fsm_busy, 0);
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_addr", memory_address, 0);
        chk("abort_wr", write_data_array, 0);
        chk("abort_idx", word_index, 0);
        chk("abort_fill_data", fill_data, 0);
        chk("abort_tag", write_tag_array, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 16'h0000, 1, 1);
        chk("abort_no_tag", n_tag_obs, 0);

        // Block at the top of the address space.
        n_rd_obs = 0; n_tag_obs = 0; lat = 3;
        step(0, 1, 16'hFFFE, 1, 0);
        for (int i = 1; i <= 14; i++) step(0, 0, 16'h0000, 1, 0);
        chk("top_rd_count", n_rd_obs, 8);
        chk("top_last_addr", last_rd_addr, 16'hFFFE);
        chk("top_tag_count", n_tag_obs, 1);

        // Random traffic: misses, grant gaps, varied latency, stray valids and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 299) == 0);
            if (!m_busy && $urandom_range(0, 3) == 0) lat = $urandom_range(1, 6);
            step(r, $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 9) < 7, 1);
        end

        // Four-word, 32-bit configuration with a two-cycle memory.
        #1;
        r4_rst_n = 1'b1; r4_miss = 1'b1; r4_addr = 16'h0107; r4_grant = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            #1;
            r4_miss = 1'b0;
            r4_data = $urandom;
            if (p4.size() > 0 && p4[0] <= c) begin
                r4_valid = 1'b1;
                void'(p4.pop_front());
            end else begin
                r4_valid = 1'b0;
            end
            #4;
            if (c == 1) chk("w4_busy_start", o4_busy, 1);
            if (o4_rd) begin
                a4.push_back(o4_addr);
                p4.push_back(c + 2);
            end
            if (o4_wr) begin
                chk("w4_index", o4_idx, n4_wr);
                chk("w4_data", o4_fdata, r4_data);
                n4_wr++;
            end
            if (o4_tag) begin
                n4_tag++;
                tag4_at = n4_wr;
            end
            @(posedge clk);
        end
        #1;
        chk("w4_req_count", a4.size(), 4);
        for (int i = 0; i < a4.size(); i++) chk("w4_req_addr", a4[i], 16'h0100 + 16'(4 * i));
        chk("w4_wr_count", n4_wr, 4);
        chk("w4_tag_count", n4_tag, 1);
        chk("w4_tag_on_return", tag4_at, 4);
        chk("w4_busy_end", o4_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
